// File: rtl/stream_mux_2x1_rr_pkg.sv
// stream_mux_2x1_rr_pkg: shared grant encoding and default data width for the stream mux family
package stream_mux_2x1_rr_pkg;
    localparam int DEFAULT_WIDTH = 8;
    typedef enum logic {GRANT_IN0 = 1'b0, GRANT_IN1 = 1'b1} grant_e;
endpackage

// File: rtl/stream_mux_2x1_rr_arbiter.sv
// rr_arbiter_2: two-requester round-robin grant, combinational; pointer and lock state live in the caller
module rr_arbiter_2
    import stream_mux_2x1_rr_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    input  logic       lock,
    output logic       grant
);
    // a lock holds the current packet owner; otherwise a tie goes to the channel not served last
    always_comb begin
        grant = lock ? last_grant :
                (req == 2'b11) ? !last_grant :
                req[1] ? GRANT_IN1 : GRANT_IN0;
    end
endmodule

// File: rtl/stream_mux_2x1_rr.sv
// stream_mux_2x1_rr: 2:1 valid/ready stream merge with round-robin arbitration and one registered output stage; STREAM_MUX_PKT_LOCK_EN adds packet locking
module stream_mux_2x1_rr
    import stream_mux_2x1_rr_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in0_data,
    input  logic             in0_valid,
    output logic             in0_ready,
    input  logic [WIDTH-1:0] in1_data,
    input  logic             in1_valid,
    output logic             in1_ready,
`ifdef STREAM_MUX_PKT_LOCK_EN
    input  logic             in0_last,
    input  logic             in1_last,
    output logic             y_last,
`endif
    output logic [WIDTH-1:0] y_data,
    output logic             y_valid,
    input  logic             y_ready,
    output logic             y_sel
);
    logic load_en, any_valid, grant, last_grant, lock, xfer;

    rr_arbiter_2 u_arb (
        .req        ({in1_valid, in0_valid}),
        .last_grant (last_grant),
        .lock       (lock),
        .grant      (grant)
    );

    // y_ready reaches the input readies combinationally; there is no skid buffer
    assign load_en   = !y_valid | y_ready;
    assign any_valid = in0_valid | in1_valid;
    assign in0_ready = load_en & any_valid & (grant == GRANT_IN0);
    assign in1_ready = load_en & any_valid & (grant == GRANT_IN1);
    assign xfer      = (in0_valid & in0_ready) | (in1_valid & in1_ready);

`ifndef STREAM_MUX_PKT_LOCK_EN
    assign lock = 1'b0;
`endif

    // output stage: load the granted beat, drain when consumed, freeze under backpressure
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_data     <= '0;
            y_valid    <= 1'b0;
            y_sel      <= GRANT_IN0;
            last_grant <= GRANT_IN1;
`ifdef STREAM_MUX_PKT_LOCK_EN
            y_last     <= 1'b0;
            lock       <= 1'b0;
`endif
        end else if (xfer) begin
            y_data     <= (grant == GRANT_IN1) ? in1_data : in0_data;
            y_valid    <= 1'b1;
            y_sel      <= grant;
            last_grant <= grant;
`ifdef STREAM_MUX_PKT_LOCK_EN
            y_last     <= (grant == GRANT_IN1) ? in1_last : in0_last;
            lock       <= (grant == GRANT_IN1) ? !in1_last : !in0_last;
`endif
        end else if (y_ready) begin
            y_valid    <= 1'b0;
        end
    end
endmodule
